fifo_read_scheduler: RTL and testbench

FIFO_READ_SCHEDULER -- requirements
Module: fifo_read_scheduler

---
 rtl/fifo_read_scheduler_if.sv | 22 ++
 rtl/fifo_read_scheduler.sv | 104 ++++++++++
 tb/tb_fifo_read_scheduler.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_scheduler_if.sv
// Handshake bundle between four channel FIFOs, the read scheduler and its consumer.
// The scheduler sits on the slave modport; the producer/consumer side uses master.
interface fifo_read_scheduler_if;
  logic [3:0] wen;
  logic       out_ready;
  logic [3:0] ren;
  logic [1:0] grant_id;
  logic       valid;
  logic [3:0] empty;
  logic [3:0] full;
  logic [3:0] ovf;

  modport master (
    output wen, out_ready,
    input  ren, grant_id, valid, empty, full, ovf
  );

  modport slave (
    input  wen, out_ready,
    output ren, grant_id, valid, empty, full, ovf
  );
endinterface

// File: rtl/fifo_read_scheduler.sv
// Round-robin read scheduler over four FIFOs; ren is combinational, valid/grant_id follow one cycle later.
// out_ready low suppresses grants; define ARB_BURST_EN to allow up to BURST consecutive grants per channel.
module fifo_read_scheduler #(
  parameter int DEPTH = 8,
  parameter int BURST = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_read_scheduler_if.slave bus
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] DEPTH_L = OW'(DEPTH);
  localparam logic [OW-1:0] ONE_L   = OW'(1);

  if (BURST < 1 || BURST > 15) begin : g_bad_burst
    $error("fifo_read_scheduler: BURST must be within 1..15");
  end

  logic [OW-1:0] occ [4];
  logic [1:0]    ptr;
  logic [3:0]    elig;
  logic [3:0]    ren_c;
  logic [1:0]    gnt_idx;
  logic          gnt;
  logic [1:0]    cand;

  always_comb begin
    bus.empty = '0;
    bus.full  = '0;
    elig      = '0;
    for (int i = 0; i < 4; i++) begin
      bus.empty[i] = (occ[i] == '0);
      bus.full[i]  = (occ[i] == DEPTH_L);
      // A channel being written this cycle is skipped so read and write never collide.
      elig[i]      = rst_n && bus.out_ready && !bus.wen[i] && (occ[i] != '0);
    end
  end

  always_comb begin
    gnt     = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!gnt && elig[cand]) begin
        gnt     = 1'b1;
        gnt_idx = cand;
      end
    end
    ren_c   = gnt ? (4'b0001 << gnt_idx) : 4'b0000;
    bus.ren = ren_c;
  end

`ifdef ARB_BURST_EN
  localparam logic [3:0] BURST_L = 4'(BURST);
  logic [3:0] burst_cnt;
  logic [3:0] cnt_next;

  // grant_id holds the previous holder, so it doubles as the burst owner tag.
  always_comb begin
    cnt_next = 4'd1;
    if (gnt_idx == bus.grant_id) cnt_next = burst_cnt + 4'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) occ[i] <= '0;
      ptr          <= 2'd0;
      bus.valid    <= 1'b0;
      bus.grant_id <= 2'd0;
      bus.ovf      <= 4'b0000;
`ifdef ARB_BURST_EN
      burst_cnt    <= 4'd0;
`endif
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wen[i]) begin
          if (bus.full[i]) bus.ovf[i] <= 1'b1;
          else             occ[i]     <= occ[i] + ONE_L;
        end else if (ren_c[i]) begin
          occ[i] <= occ[i] - ONE_L;
        end
      end
      bus.valid <= gnt;
      if (gnt) begin
        bus.grant_id <= gnt_idx;
`ifdef ARB_BURST_EN
        if (cnt_next == BURST_L) begin
          ptr       <= gnt_idx + 2'd1;
          burst_cnt <= 4'd0;
        end else begin
          ptr       <= gnt_idx;
          burst_cnt <= cnt_next;
        end
`else
        ptr <= gnt_idx + 2'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Directed bench for fifo_read_scheduler: inputs change on the falling edge, outputs sampled away from the rising edge.
module tb_fifo_read_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fifo_read_scheduler_if bus();

  fifo_read_scheduler #(.DEPTH(8), .BURST(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.wen = 4'b0000;
    bus.out_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wen = 4'b1111;
    bus.out_ready = 1'b1;
    step();
    step();
    #1;
    checks++; if (bus.ren !== 4'b0000) begin errors++; $display("FAIL reset_ren: got %b expected 0000", bus.ren); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", bus.grant_id); end
    checks++; if (bus.empty !== 4'b1111) begin errors++; $display("FAIL reset_empty: got %b expected 1111", bus.empty); end
    checks++; if (bus.full !== 4'b0000) begin errors++; $display("FAIL reset_full: got %b expected 0000", bus.full); end
    checks++; if (bus.ovf !== 4'b0000) begin errors++; $display("FAIL reset_ovf: got %b expected 0000", bus.ovf); end
    rst_n = 1'b1;
    bus.wen = 4'b0000;
    bus.out_ready = 1'b0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    bus.out_ready = 1'b1;
    bus.wen = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.ren !== 4'b0000) begin errors++; $display("FAIL single_ren_during_write%0d: got %b expected 0000", k, bus.ren); end
      step();
    end
    bus.wen = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.ren !== 4'b0001) begin errors++; $display("FAIL single_ren%0d: got %b expected 0001", k, bus.ren); end
      step();
      checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL single_valid%0d: got %b expected 1", k, bus.valid); end
      checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL single_grant_id%0d: got %0d expected 0", k, bus.grant_id); end
    end
    #1;
    checks++; if (bus.ren !== 4'b0000) begin errors++; $display("FAIL single_ren_drained: got %b expected 0000", bus.ren); end
    checks++; if (bus.empty[0] !== 1'b1) begin errors++; $display("FAIL single_empty0: got %b expected 1", bus.empty[0]); end
    step();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL single_valid_after: got %b expected 0", bus.valid); end
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL single_grant_hold: got %0d expected 0", bus.grant_id); end
  endtask

  task automatic test_round_robin();
`ifdef ARB_BURST_EN
    int exp_id [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
    int exp_id [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    logic [3:0] exp_ren;
    do_reset();
    bus.out_ready = 1'b1;
    bus.wen = 4'b1111;
    step();
    step();
    bus.wen = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      exp_ren = 4'b0001 << exp_id[k];
      #1;
      checks++; if (bus.ren !== exp_ren) begin errors++; $display("FAIL rr_ren%0d: got %b expected %b", k, bus.ren, exp_ren); end
      step();
      checks++; if (bus.valid !== 1'b1 || bus.grant_id !== 2'(exp_id[k])) begin
        errors++; $display("FAIL rr_grant%0d: got valid=%b id=%0d expected valid=1 id=%0d", k, bus.valid, bus.grant_id, exp_id[k]);
      end
    end
    #1;
    checks++; if (bus.empty !== 4'b1111) begin errors++; $display("FAIL rr_empty: got %b expected 1111", bus.empty); end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.wen = 4'b0100;
    repeat (8) step();
    #1;
    checks++; if (bus.full !== 4'b0100) begin errors++; $display("FAIL ovf_full_at8: got %b expected 0100", bus.full); end
    checks++; if (bus.ovf !== 4'b0000) begin errors++; $display("FAIL ovf_clear_at8: got %b expected 0000", bus.ovf); end
    step();
    bus.wen = 4'b0000;
    #1;
    checks++; if (bus.full !== 4'b0100) begin errors++; $display("FAIL ovf_full_at9: got %b expected 0100", bus.full); end
    checks++; if (bus.ovf !== 4'b0100) begin errors++; $display("FAIL ovf_set: got %b expected 0100", bus.ovf); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (bus.ren !== 4'b0100) begin errors++; $display("FAIL ovf_read%0d: got %b expected 0100", k, bus.ren); end
      step();
    end
    #1;
    checks++; if (bus.ren !== 4'b0000) begin errors++; $display("FAIL ovf_ren_drained: got %b expected 0000", bus.ren); end
    checks++; if (bus.empty[2] !== 1'b1) begin errors++; $display("FAIL ovf_empty2: got %b expected 1", bus.empty[2]); end
    checks++; if (bus.ovf !== 4'b0100) begin errors++; $display("FAIL ovf_sticky: got %b expected 0100", bus.ovf); end
  endtask

  task automatic test_write_blocks_read();
    do_reset();
    bus.wen = 4'b1011;
    step();
    bus.wen = 4'b0000;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.ren !== 4'b0001) begin errors++; $display("FAIL wb_first: got %b expected 0001", bus.ren); end
    step();
    bus.wen = 4'b0010;
    #1;
    checks++; if (bus.ren !== 4'b1000) begin errors++; $display("FAIL wb_skip_ch1: got %b expected 1000", bus.ren); end
    step();
    bus.wen = 4'b0000;
    checks++; if (bus.grant_id !== 2'd3) begin errors++; $display("FAIL wb_grant3: got %0d expected 3", bus.grant_id); end
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (bus.ren !== 4'b0010) begin errors++; $display("FAIL wb_ch1_%0d: got %b expected 0010", k, bus.ren); end
      step();
      checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("FAIL wb_grant1_%0d: got %0d expected 1", k, bus.grant_id); end
    end
    #1;
    checks++; if (bus.empty !== 4'b1111) begin errors++; $display("FAIL wb_empty: got %b expected 1111", bus.empty); end
  endtask

  task automatic test_backpressure_and_reset();
    do_reset();
    bus.wen = 4'b1001;
    step();
    step();
    bus.wen = 4'b1000;
    repeat (7) step();
    bus.wen = 4'b0000;
    #1;
    checks++; if (bus.ovf !== 4'b1000) begin errors++; $display("FAIL bp_ovf3: got %b expected 1000", bus.ovf); end
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (bus.ren !== 4'b0000) begin errors++; $display("FAIL bp_ren%0d: got %b expected 0000", k, bus.ren); end
      step();
      checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL bp_valid%0d: got %b expected 0", k, bus.valid); end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.ren !== 4'b0001) begin errors++; $display("FAIL bp_resume: got %b expected 0001", bus.ren); end
    step();
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL bp_resume_valid: got %b expected 1", bus.valid); end
    rst_n = 1'b0;
    bus.wen = 4'b1111;
    #1;
    checks++; if (bus.ren !== 4'b0000) begin errors++; $display("FAIL bp_ren_in_reset: got %b expected 0000", bus.ren); end
    step();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL bp_reset_valid: got %b expected 0", bus.valid); end
    checks++; if (bus.empty !== 4'b1111) begin errors++; $display("FAIL bp_reset_empty: got %b expected 1111", bus.empty); end
    checks++; if (bus.ovf !== 4'b0000) begin errors++; $display("FAIL bp_reset_ovf: got %b expected 0000", bus.ovf); end
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL bp_reset_grant_id: got %0d expected 0", bus.grant_id); end
    rst_n = 1'b1;
    bus.wen = 4'b0000;
    step();
  endtask

`ifdef ARB_BURST_EN
  task automatic test_burst();
    int exp_id [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    do_reset();
    bus.out_ready = 1'b1;
    bus.wen = 4'b1111;
    repeat (4) step();
    bus.wen = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (bus.valid !== 1'b1 || bus.grant_id !== 2'(exp_id[k])) begin
        errors++; $display("FAIL burst_grant%0d: got valid=%b id=%0d expected valid=1 id=%0d", k, bus.valid, bus.grant_id, exp_id[k]);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus.wen = 4'b0000;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_write_blocks_read();
    test_backpressure_and_reset();
`ifdef ARB_BURST_EN
    test_burst();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
